// File: rtl/dcmi_pkg.sv
// Shared definitions for the DCMI stream transmitter: FSM state encoding
// and a width helper used to size the line and gap counters.
package dcmi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VPRE  = 3'd1,
        ST_LINE  = 3'd2,
        ST_GAP   = 3'd3,
        ST_VPOST = 3'd4
    } tx_state_t;

    // Bits needed to count 0..value-1; never narrower than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dcmi_bank_ram.sv
// Simple dual-port RAM holding both ping-pong banks; the bank select is the
// address MSB. Read data is registered (one clock latency) and not reset.
module dcmi_bank_ram #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW:0]   i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW:0]   i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**(AW+1)];
    logic [DW-1:0] r_rdata;

    // Write port and registered read port.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dcmi_stream_tx.sv
// DCMI frame transmitter with ping-pong buffering: one bank is filled by the
// host while the other is streamed out as VSYNC/HSYNC framed pixel data.
module dcmi_stream_tx
    import dcmi_pkg::*;
#(
    parameter int DW       = 8,
    parameter int AW       = 10,
    parameter int DIV_BITS = 1,
    parameter int LINE_LEN = 256,
    parameter int GAP      = 4
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    input  logic [DW-1:0] i_di,
    input  logic          i_wr,
    input  logic          i_rst_wr,
    input  logic          i_start,
    output logic [DW-1:0] o_data,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_dclk,
    output logic          o_busy,
    output logic          o_err,
    output logic          o_ovf
);

    localparam int CW = clog2(LINE_LEN);
    localparam int GW = clog2(GAP);
    localparam logic [AW:0]   L_FULL     = {1'b1, {AW{1'b0}}};
    localparam logic [CW-1:0] L_COL_LAST = CW'(LINE_LEN - 1);
    localparam logic [GW-1:0] L_GAP_LAST = GW'(GAP - 1);

    tx_state_t r_state, w_state_next;

    logic [DIV_BITS-1:0] r_div;
    logic [AW:0]         r_wptr, w_wptr_next;
    logic [AW:0]         r_len, r_sent;
    logic [CW-1:0]       r_col;
    logic [GW-1:0]       r_gap;
    logic [DW-1:0]       r_data, w_rdata;
    logic                r_bank, r_ovf, r_busy, r_go, r_err;
    logic                w_clk_en, w_we, w_ovf_set, w_accept;

    assign w_clk_en = &r_div;

    // Pixel clock divider; outputs only move on the cycle the divider wraps.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_BITS'(1);
        end
    end

    // Write-pointer next value; RST_WR beats WR, a full bank drops the word.
    always_comb begin
        w_we        = 1'b0;
        w_ovf_set   = 1'b0;
        w_wptr_next = r_wptr;
        if (i_rst_wr) begin
            w_wptr_next = '0;
        end else if (i_wr) begin
            if (r_wptr == L_FULL) begin
                w_ovf_set = 1'b1;
            end else begin
                w_we        = 1'b1;
                w_wptr_next = r_wptr + (AW+1)'(1);
            end
        end
    end

    // A same-cycle write counts toward the committed frame length.
    assign w_accept = i_start && !r_busy && (w_wptr_next != '0);

    // Write side, bank swap on commit, overflow flag and reject pulse.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_wptr <= '0;
            r_bank <= 1'b0;
            r_ovf  <= 1'b0;
            r_len  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= i_start && r_busy;
            if (w_accept) begin
                r_wptr <= '0;
                r_bank <= ~r_bank;
                r_ovf  <= 1'b0;
                r_len  <= w_wptr_next;
            end else begin
                r_wptr <= w_wptr_next;
                if (i_rst_wr) begin
                    r_ovf <= 1'b0;
                end else if (w_ovf_set) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    // BUSY spans acceptance to the end of VPOST; go defers the frame to a tick.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_busy <= 1'b0;
            r_go   <= 1'b0;
        end else if (w_accept) begin
            r_busy <= 1'b1;
            r_go   <= 1'b1;
        end else if (w_clk_en) begin
            if (r_state == ST_IDLE) begin
                r_go <= 1'b0;
            end
            if (r_state == ST_VPOST) begin
                r_busy <= 1'b0;
            end
        end
    end

    // FSM state register, advanced once per DCLK period.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= ST_IDLE;
        end else if (w_clk_en) begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: frame preamble, lines, inter-line gaps, postamble.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (r_go) w_state_next = ST_VPRE;
            ST_VPRE:  w_state_next = ST_LINE;
            ST_LINE: begin
                if (r_sent == r_len) begin
                    w_state_next = ST_VPOST;
                end else if (r_col == L_COL_LAST) begin
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP:   if (r_gap == L_GAP_LAST) w_state_next = ST_LINE;
            ST_VPOST: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Word/column/gap counters; r_sent also serves as the prefetch address.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_sent <= '0;
            r_col  <= '0;
            r_gap  <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_sent <= '0;
        end else if (w_clk_en) begin
            if (w_state_next == ST_LINE) begin
                r_data <= w_rdata;
                r_sent <= r_sent + (AW+1)'(1);
                r_col  <= (r_state == ST_LINE) ? r_col + CW'(1) : '0;
            end
            if (w_state_next == ST_GAP) begin
                r_gap <= (r_state == ST_GAP) ? r_gap + GW'(1) : '0;
            end
        end
    end

    dcmi_bank_ram #(
        .DW(DW),
        .AW(AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr ({r_bank, r_wptr[AW-1:0]}),
        .i_wdata (i_di),
        .i_raddr ({~r_bank, r_sent[AW-1:0]}),
        .o_rdata (w_rdata)
    );

    // FSM outputs: sync levels from state, DATA forced to 0 outside lines.
    always_comb begin
        o_vsync = (r_state != ST_IDLE);
        o_hsync = (r_state == ST_LINE);
        o_data  = (r_state == ST_LINE) ? r_data : '0;
    end

    assign o_dclk = r_div[DIV_BITS-1];
    assign o_busy = r_busy;
    assign o_err  = r_err;
    assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_dcmi_stream_tx.sv
// Scoreboard bench for dcmi_stream_tx: stimulus pushes the expected
// per-DCLK-period {HSYNC, DATA} sequence of each frame; a monitor pops and
// compares once per DCLK period while VSYNC is high.
module tb_dcmi_stream_tx;

    localparam int LL = 4;
    localparam int GP = 2;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic [7:0] di = 8'h00;
    logic       wr = 1'b0;
    logic       rst_wr = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data;
    logic       hsync, vsync, dclk, busy, err, ovf;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    logic [7:0] words[$];
    logic [8:0] mon_e;

    dcmi_stream_tx #(
        .DW(8), .AW(4), .DIV_BITS(1), .LINE_LEN(LL), .GAP(GP)
    ) dut (
        .i_clk(clk), .i_nrst(nrst), .i_di(di), .i_wr(wr), .i_rst_wr(rst_wr),
        .i_start(start), .o_data(data), .o_hsync(hsync), .o_vsync(vsync),
        .o_dclk(dclk), .o_busy(busy), .o_err(err), .o_ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end else begin
            $display("ok   %s act=%0h", name, act);
        end
    endtask

    // Expected frame: VPRE, lines of LL words separated by GP gap periods, VPOST.
    task automatic push_frame();
        exp_q.push_back(9'h000);
        for (int i = 0; i < words.size(); i++) begin
            if (i > 0 && (i % LL) == 0) begin
                for (int g = 0; g < GP; g++) exp_q.push_back(9'h000);
            end
            exp_q.push_back({1'b1, words[i]});
        end
        exp_q.push_back(9'h000);
    endtask

    task automatic wr_word(input logic [7:0] v);
        @(negedge clk);
        di = v;
        wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_words(input logic [7:0] first, input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(first + 8'(i));
    endtask

    task automatic write_words();
        for (int i = 0; i < words.size(); i++) wr_word(words[i]);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (busy && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout act=busy_high req=busy_low", name);
        end else begin
            chk({name, "_vsync_at_busy_fall"}, {31'd0, vsync}, 32'd0);
            chk({name, "_periods_left"}, exp_q.size(), 32'd0);
        end
    endtask

    // Monitor: one comparison per DCLK period while a frame is on the wire.
    always @(negedge clk) begin
        if (nrst && dclk && vsync) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL frame_period act=hs%0d_d%02h req=no_period", hsync, data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({hsync, data} !== mon_e) begin
                    errors++;
                    $display("FAIL frame_period act=hs%0d_d%02h req=hs%0d_d%02h",
                             hsync, data, mon_e[8], mon_e[7:0]);
                end else begin
                    $display("ok   frame_period hs%0d_d%02h", hsync, data);
                end
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_in_frame act=%0d req=1", busy);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=running req=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int rises;
        logic prev_hs;
        logic seen;

        // Reset state
        #1 nrst = 1'b0;
        #2;
        chk("rst_data",  {24'd0, data}, 32'd0);
        chk("rst_hsync", {31'd0, hsync}, 32'd0);
        chk("rst_vsync", {31'd0, vsync}, 32'd0);
        chk("rst_dclk",  {31'd0, dclk}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_err",   {31'd0, err}, 32'd0);
        chk("rst_ovf",   {31'd0, ovf}, 32'd0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;

        // Basic frame 0x01..0x0A: lines 4,4,2
        load_words(8'h01, 10);
        write_words();
        push_frame();
        start_pulse();
        chk("basic_busy_on_accept", {31'd0, busy}, 32'd1);
        chk("basic_no_err", {31'd0, err}, 32'd0);
        wait_done("basic");

        // Frame 0x31..0x36 with a rejected START in LINE; next frame written meanwhile
        load_words(8'h31, 6);
        write_words();
        push_frame();
        start_pulse();
        n = 0;
        while (!hsync && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reject_reached_line", {31'd0, hsync}, 32'd1);
        start_pulse();
        chk("reject_err_pulse", {31'd0, err}, 32'd1);
        @(negedge clk);
        chk("reject_err_width", {31'd0, err}, 32'd0);
        load_words(8'h20, 8);
        write_words();
        wait_done("reject");

        // Second buffer 0x20..0x27
        push_frame();
        start_pulse();
        chk("dbuf_busy", {31'd0, busy}, 32'd1);
        wait_done("dbuf");

        // Overflow: 17 writes, only 16 sent
        load_words(8'h01, 16);
        write_words();
        chk("ovf_at_16", {31'd0, ovf}, 32'd0);
        wr_word(8'h11);
        chk("ovf_at_17", {31'd0, ovf}, 32'd1);
        push_frame();
        start_pulse();
        chk("ovf_cleared_by_start", {31'd0, ovf}, 32'd0);
        wait_done("ovf");

        // WR and START in the same cycle: last word is part of the frame
        load_words(8'h41, 3);
        wr_word(8'h41);
        wr_word(8'h42);
        push_frame();
        @(negedge clk);
        di = 8'h43;
        wr = 1'b1;
        start = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        start = 1'b0;
        chk("wrstart_busy", {31'd0, busy}, 32'd1);
        wait_done("wrstart");

        // Mid-frame reset in the second line
        load_words(8'h51, 8);
        write_words();
        push_frame();
        start_pulse();
        rises = 0;
        prev_hs = 1'b0;
        n = 0;
        while (rises < 2 && n < 200) begin
            @(negedge clk);
            if (hsync && !prev_hs) rises++;
            prev_hs = hsync;
            n++;
        end
        chk("midrst_second_line", rises, 32'd2);
        #2 nrst = 1'b0;
        #1;
        chk("midrst_data",  {24'd0, data}, 32'd0);
        chk("midrst_hsync", {31'd0, hsync}, 32'd0);
        chk("midrst_vsync", {31'd0, vsync}, 32'd0);
        chk("midrst_dclk",  {31'd0, dclk}, 32'd0);
        chk("midrst_busy",  {31'd0, busy}, 32'd0);
        chk("midrst_err",   {31'd0, err}, 32'd0);
        chk("midrst_ovf",   {31'd0, ovf}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        start_pulse();
        chk("empty_start_no_err", {31'd0, err}, 32'd0);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (vsync || busy) seen = 1'b1;
        end
        chk("empty_start_stays_idle", {31'd0, seen}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
